// File: rtl/hbd_rx_detector_pkg.sv
// Shared constants for the HAPPY BIRTHDAY serial link: the pattern bytes and
// the receiver state encoding, used by both transmitter and detector.
package hbd_pkg;

  localparam int PATTERN_LEN = 14;

  localparam logic [0:PATTERN_LEN-1][7:0] PATTERN = {
    8'h48, 8'h41, 8'h50, 8'h50, 8'h59, 8'h20, 8'h42,
    8'h49, 8'h52, 8'h54, 8'h48, 8'h44, 8'h41, 8'h59
  };

  localparam logic [7:0] CHAR_H = 8'h48;
  localparam logic [7:0] CHAR_A = 8'h41;

  // Position after "HAPPY BIRTH": an 'A' here leaves "HA" as a live prefix.
  localparam logic [3:0] K_BORDER = 4'd11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/hbd_rx_detector_if.sv
// Serial input and detector result bundle; the detector sits on the slave
// side, the line driver / display path on the master side.
interface hbd_rx_detector_if #(
  parameter int HIT_W = 6
);

  logic             i_rx_serial;
  logic [7:0]       o_rx_data;
  logic             o_rx_valid;
  logic             o_frame_err;
  logic [HIT_W-1:0] o_hit_count;
  logic             o_hit_valid;

  modport slave (
    input  i_rx_serial,
    output o_rx_data,
    output o_rx_valid,
    output o_frame_err,
    output o_hit_count,
    output o_hit_valid
  );

  modport master (
    output i_rx_serial,
    input  o_rx_data,
    input  o_rx_valid,
    input  o_frame_err,
    input  o_hit_count,
    input  o_hit_valid
  );

endinterface

// File: rtl/hbd_rx_detector_uart_rx.sv
// 8N1 receiver: 2-flop line synchronizer, mid-bit sampling FSM and
// registered byte / valid / frame-error outputs.
module hbd_uart_rx
  import hbd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_sync;
  logic             w_rx;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx_serial};
    end
  end

  assign w_rx = r_sync[1];

  // Counter restarts at every sample so each sample lands mid-bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!w_rx) r_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= RX_IDLE;
            if (w_rx) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/hbd_rx_detector.sv
// Receives serial characters and counts complete "HAPPY BIRTHDAY" occurrences
// in the byte stream; feeds the seven-segment hit display.
module hbd_rx_detector
  import hbd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int HIT_W        = 6
) (
  input logic               i_clk,
  input logic               i_rst_n,
  hbd_rx_detector_if.slave  bus
);

  localparam logic [3:0] K_LAST = 4'(PATTERN_LEN - 1);

  logic [7:0]       w_rx_data;
  logic             w_rx_valid;
  logic             w_frame_err;
  logic [3:0]       r_k;
  logic [3:0]       w_k_next;
  logic             w_hit;
  logic [HIT_W-1:0] r_hit_count;
  logic             r_hit_valid;

  hbd_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_serial (bus.i_rx_serial),
    .o_rx_data   (w_rx_data),
    .o_rx_valid  (w_rx_valid),
    .o_frame_err (w_frame_err)
  );

  // Fallbacks are the longest pattern prefix that is still a suffix of the input.
  always_comb begin
    w_k_next = r_k;
    w_hit    = 1'b0;
    if (w_frame_err) begin
      w_k_next = '0;
    end else if (w_rx_valid) begin
      if (w_rx_data == PATTERN[r_k]) begin
        if (r_k == K_LAST) begin
          w_k_next = '0;
          w_hit    = 1'b1;
        end else begin
          w_k_next = r_k + 1'b1;
        end
      end else if (r_k == K_BORDER && w_rx_data == CHAR_A) begin
        w_k_next = 4'd2;
      end else if (w_rx_data == CHAR_H) begin
        w_k_next = 4'd1;
      end else begin
        w_k_next = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k         <= '0;
      r_hit_count <= '0;
      r_hit_valid <= 1'b0;
    end else begin
      r_k         <= w_k_next;
      r_hit_valid <= w_hit;
      if (w_hit) r_hit_count <= r_hit_count + 1'b1;
    end
  end

  assign bus.o_rx_data   = w_rx_data;
  assign bus.o_rx_valid  = w_rx_valid;
  assign bus.o_frame_err = w_frame_err;
  assign bus.o_hit_count = r_hit_count;
  assign bus.o_hit_valid = r_hit_valid;

endmodule

// File: tb/tb_hbd_rx_detector.sv
// Directed bench for hbd_rx_detector: table of byte strings with hand-computed
// hit/error counts, plus reset, glitch, latency and counter-wrap sequences.
module tb_hbd_rx_detector;
  import hbd_pkg::*;

  typedef struct {
    string text;
    int    errPos;
    int    expErrs;
    int    expHits;
    int    expCount;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  hbd_rx_detector_if #(.HIT_W(6)) bus16 ();
  hbd_rx_detector_if #(.HIT_W(6)) bus4 ();

  hbd_rx_detector #(.CLKS_PER_BIT(16), .HIT_W(6)) dut16 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus16.slave)
  );

  // Fast-baud copy so the 64-pattern wrap run stays short.
  hbd_rx_detector #(.CLKS_PER_BIT(4), .HIT_W(6)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus4.slave)
  );

  int numChecks = 0;
  int numFails  = 0;
  logic [7:0] rxQ16[$];
  int errCnt16 = 0, hitCnt16 = 0;
  int validCnt4 = 0, errCnt4 = 0, hitCnt4 = 0;
  int lat;
  vec_t vecs[7];

  always @(negedge clk) begin
    if (bus16.o_rx_valid)  rxQ16.push_back(bus16.o_rx_data);
    if (bus16.o_frame_err) errCnt16++;
    if (bus16.o_hit_valid) hitCnt16++;
    if (bus4.o_rx_valid)   validCnt4++;
    if (bus4.o_frame_err)  errCnt4++;
    if (bus4.o_hit_valid)  hitCnt4++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveLine(input bit fast, input logic v);
    if (fast) bus4.i_rx_serial = v;
    else      bus16.i_rx_serial = v;
  endtask

  task automatic driveBit(input bit fast, input logic v, input int cycles);
    driveLine(fast, v);
    repeat (cycles) @(negedge clk);
  endtask

  // A bad frame holds the stop bit low only past its mid-bit sample, then
  // returns high so the tail is not mistaken for a new start bit.
  task automatic sendFrame(input bit fast, input logic [7:0] b, input bit stopOk);
    int cpb;
    cpb = fast ? 4 : 16;
    driveBit(fast, 1'b0, cpb);
    for (int i = 0; i < 8; i++) driveBit(fast, b[i], cpb);
    if (stopOk) begin
      driveBit(fast, 1'b1, cpb);
    end else begin
      driveBit(fast, 1'b0, cpb / 2 + 2);
      driveBit(fast, 1'b1, cpb / 2 - 2 + cpb);
    end
  endtask

  task automatic sendText(input bit fast, input string s, input int errPos);
    for (int i = 0; i < s.len(); i++) sendFrame(fast, s[i], i != errPos);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int rxBase, errBase, hitBase, j, got;
    rxBase  = rxQ16.size();
    errBase = errCnt16;
    hitBase = hitCnt16;
    sendText(1'b0, v.text, v.errPos);
    repeat (24) @(negedge clk);
    checkOutput($sformatf("v%0d_rx_count", idx), rxQ16.size() - rxBase, v.text.len() - v.expErrs);
    j = 0;
    for (int i = 0; i < v.text.len(); i++) begin
      if (i != v.errPos) begin
        got = (rxBase + j < rxQ16.size()) ? int'(rxQ16[rxBase + j]) : -1;
        checkOutput($sformatf("v%0d_byte%0d", idx, i), got, int'(v.text[i]));
        j++;
      end
    end
    checkOutput($sformatf("v%0d_frame_errs", idx), errCnt16 - errBase, v.expErrs);
    checkOutput($sformatf("v%0d_hit_pulses", idx), hitCnt16 - hitBase, v.expHits);
    checkOutput($sformatf("v%0d_hit_count", idx), int'(bus16.o_hit_count), v.expCount);
  endtask

  initial begin
    int rxBase, errBase, validBase, hitBase;

    vecs[0] = '{"HAPPY BIRTHDAY",              -1, 0, 1, 1};
    vecs[1] = '{"HAPPY BIRTHAPPY BIRTHDAY",    -1, 0, 1, 2};
    vecs[2] = '{"HAPPY BIRXTHDAY",              9, 1, 0, 2};
    vecs[3] = '{"HAPPY BIRTHDAY",              -1, 0, 1, 3};
    vecs[4] = '{"happy birthday",              -1, 0, 0, 3};
    vecs[5] = '{"HHAPPY BIRTHDAY",             -1, 0, 1, 4};
    vecs[6] = '{"HAPPY BIRTHDAHAPPY BIRTHDAY", -1, 0, 1, 5};

    bus16.i_rx_serial = 1'b1;
    bus4.i_rx_serial  = 1'b1;
    rstN = 1'b1;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_data",   int'(bus16.o_rx_data), 0);
    checkOutput("rst_rx_valid",  int'(bus16.o_rx_valid), 0);
    checkOutput("rst_frame_err", int'(bus16.o_frame_err), 0);
    checkOutput("rst_hit_count", int'(bus16.o_hit_count), 0);
    checkOutput("rst_hit_valid", int'(bus16.o_hit_valid), 0);
    checkOutput("rst_state",     int'(dut16.u_rx.r_state), int'(RX_IDLE));
    rstN = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("idle_rx_pulses",  rxQ16.size(), 0);
    checkOutput("idle_err_pulses", errCnt16, 0);
    checkOutput("idle_hit_pulses", hitCnt16, 0);
    checkOutput("idle_hit_count",  int'(bus16.o_hit_count), 0);
    checkOutput("idle_rx_data",    int'(bus16.o_rx_data), 0);

    $display("[TB] glitch rejection");
    rxBase  = rxQ16.size();
    errBase = errCnt16;
    driveBit(1'b0, 1'b0, 6);
    driveBit(1'b0, 1'b1, 40);
    checkOutput("glitch_rx_pulses",  rxQ16.size() - rxBase, 0);
    checkOutput("glitch_err_pulses", errCnt16 - errBase, 0);
    checkOutput("glitch_state_idle", int'(dut16.u_rx.r_state), int'(RX_IDLE));

    fork
      sendFrame(1'b0, 8'h48, 1'b1);
      begin
        lat = 0;
        wait (bus16.i_rx_serial == 1'b0);
        do begin
          @(negedge clk);
          lat++;
        end while (!bus16.o_rx_valid && lat < 400);
      end
    join
    numChecks++;
    if (lat < 154 || lat > 156) begin
      numFails++;
      $display("[TB] FAIL start_to_valid_latency: got %0d cycles, expected 155 +/- 1", lat);
    end
    repeat (24) @(negedge clk);
    checkOutput("after_glitch_rx_count", rxQ16.size() - rxBase, 1);
    checkOutput("after_glitch_byte", int'(bus16.o_rx_data), 8'h48);

    $display("[TB] pattern vector table");
    for (int v = 0; v < 7; v++) applyStimulus(vecs[v], v);

    $display("[TB] hit counter wrap");
    hitBase = hitCnt4;
    for (int p = 0; p < 63; p++) sendText(1'b1, "HAPPY BIRTHDAY", -1);
    repeat (8) @(negedge clk);
    checkOutput("wrap_count_63", int'(bus4.o_hit_count), 63);
    sendText(1'b1, "HAPPY BIRTHDAY", -1);
    repeat (8) @(negedge clk);
    checkOutput("wrap_count_0",    int'(bus4.o_hit_count), 0);
    checkOutput("wrap_hit_pulses", hitCnt4 - hitBase, 64);
    checkOutput("wrap_frame_errs", errCnt4, 0);

    $display("[TB] reset mid-frame");
    validBase = validCnt4;
    driveBit(1'b1, 1'b0, 4);
    for (int i = 0; i < 6; i++) driveBit(1'b1, PATTERN[6][i], 4);
    driveBit(1'b1, PATTERN[6][6], 2);
    rstN = 1'b0;
    driveLine(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("midrst_rx_data",     int'(bus4.o_rx_data), 0);
    checkOutput("midrst_count16",     int'(bus16.o_hit_count), 0);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_partial",  validCnt4 - validBase, 0);
    checkOutput("midrst_state_idle",  int'(dut4.u_rx.r_state), int'(RX_IDLE));
    hitBase = hitCnt4;
    sendText(1'b1, "HAPPY BIRTHDAY", -1);
    repeat (8) @(negedge clk);
    checkOutput("midrst_hit_count",   int'(bus4.o_hit_count), 1);
    checkOutput("midrst_hit_pulses",  hitCnt4 - hitBase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
